// File: rtl/bram_mac_pkg.sv
// Shared types and constants for the BRAM multiply-accumulate reader.
// The saturate helper is only referenced when BRAM_MAC_SAT_EN is defined.
package bram_mac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int ACC_W_DEF  = 40;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Clamp an accumulator-width value into the signed data-word range.
  function automatic logic signed [DATA_W_DEF-1:0] saturate(
    input logic signed [ACC_W_DEF-1:0] v
  );
    logic signed [DATA_W_DEF-1:0] r;
    if (v > ACC_W_DEF'(SAT_MAX))
      r = DATA_W_DEF'(SAT_MAX);
    else if (v < ACC_W_DEF'(SAT_MIN))
      r = DATA_W_DEF'(SAT_MIN);
    else
      r = v[DATA_W_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/bram_mac_reader_rd_lat_pipe.sv
// Tag delay line matching the BRAM read latency: a bit pushed in with an
// address comes out on the cycle its read data is valid.
module rd_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             din,
  output logic             dout,
  output logic [DEPTH-1:0] stages
);

  logic [DEPTH-1:0] sr;

  // Shift towards the MSB; the MSB is the aligned output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      sr <= '0;
    else
      sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout   = sr[DEPTH-1];
  assign stages = sr;

endmodule

// File: rtl/bram_mac_reader.sv
// Streams len sample/weight pairs out of the feature/weight BRAM, forms the
// signed dot product and presents it on a valid/ready result port.
// Optional macro BRAM_MAC_SAT_EN: 16-bit shifted, saturated result.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one address pair per cycle, len cycles
// DRAIN | waiting for in-flight reads to be accumulated
// HOLD  | result valid, waiting for res_ready
module bram_mac_reader
  import bram_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 2,
  parameter int ACC_W  = ACC_W_DEF,
`ifdef BRAM_MAC_SAT_EN
  parameter int FRAC_BITS = 8,
  localparam int OUT_W = DATA_W
`else
  localparam int OUT_W = ACC_W
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic              wren_a,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data
);

  state_t                     state;
  logic [ADDR_W:0]            taps_left;
  logic                       issue_tag;
  logic                       tag_out;
  logic [RD_LAT-1:0]          tags;
  logic [RD_LAT-1:0]          upstream_tags;
  logic                       pending;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic [OUT_W-1:0]           res_next;

  assign wren_a = 1'b0;
  assign wren_b = 1'b0;

  rd_lat_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (issue_tag),
    .dout    (tag_out),
    .stages  (tags)
  );

  // Tags still behind the output stage; the output stage itself is
  // accumulated on the same edge that leaves DRAIN.
  assign upstream_tags = tags << 1;
  assign pending       = |upstream_tags;

  assign prod     = $signed(q_a) * $signed(q_b);
  assign acc_next = tag_out ? acc + ACC_W'(prod) : acc;

`ifdef BRAM_MAC_SAT_EN
  logic signed [ACC_W-1:0] acc_shift;
  assign acc_shift = acc_next >>> FRAC_BITS;
  assign res_next  = saturate(acc_shift);
`else
  assign res_next  = acc_next;
`endif

  // Sequencer: address issue, drain, and result hold with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      address_a <= '0;
      address_b <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      acc       <= '0;
      taps_left <= '0;
      issue_tag <= 1'b0;
    end else begin
      acc <= acc_next;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            acc  <= '0;
            if (len != '0) begin
              state     <= ISSUE;
              address_a <= base_a;
              address_b <= base_b;
              taps_left <= len - 1'b1;
              issue_tag <= 1'b1;
            end else begin
              state     <= HOLD;
              res_valid <= 1'b1;
              res_data  <= '0;
            end
          end
        end
        ISSUE: begin
          if (taps_left == '0) begin
            state     <= DRAIN;
            issue_tag <= 1'b0;
          end else begin
            address_a <= address_a + 1'b1;
            address_b <= address_b + 1'b1;
            taps_left <= taps_left - 1'b1;
          end
        end
        DRAIN: begin
          if (!pending) begin
            state     <= HOLD;
            res_valid <= 1'b1;
            res_data  <= res_next;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_mac_reader.sv
// Directed bench for bram_mac_reader with a 2-cycle BRAM read model.
// Works for both the full-width and the BRAM_MAC_SAT_EN build.
module tb_bram_mac_reader;

`ifdef BRAM_MAC_SAT_EN
  localparam int OW = 16;
  localparam bit SAT = 1'b1;
`else
  localparam int OW = 40;
  localparam bit SAT = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [4:0]           base_a, base_b;
  logic [5:0]           len;
  logic                 busy;
  logic [4:0]           address_a, address_b;
  logic                 wren_a, wren_b;
  logic [15:0]          q_a, q_b;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [OW-1:0] res_data;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] mem_a [32];
  logic signed [15:0] mem_b [32];
  logic [15:0]        pa1, pb1;
  int                 alog [64];
  int                 blog [64];

  always #5 clock = ~clock;

  // Two-stage registered read: address in cycle t -> q in cycle t+2.
  always @(posedge clock) begin
    pa1 <= mem_a[address_a];
    pb1 <= mem_b[address_b];
    q_a <= pa1;
    q_b <= pb1;
  end

  bram_mac_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .len       (len),
    .busy      (busy),
    .address_a (address_a),
    .address_b (address_b),
    .wren_a    (wren_a),
    .wren_b    (wren_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 16'(i + 1);
      mem_b[i] = 16'(i - 3);
    end
  endtask

  // Start a job; returns the cycle in which res_valid is first seen (-1 on timeout).
  task automatic run_job(input logic [4:0] ba, input logic [4:0] bb,
                         input logic [5:0] ln, output int lat);
    @(negedge clock);
    base_a = ba; base_b = bb; len = ln; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    base_a = ~ba; base_b = ~bb; len = 6'd63;
    lat = -1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clock);
      if (c < 64) begin
        alog[c] = int'(address_a);
        blog[c] = int'(address_b);
      end
      if (res_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_job(input string name);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    @(negedge clock);
    check({name, "_busy_after_hs"}, longint'(busy), 0);
  endtask

  typedef struct {
    logic [4:0] ba;
    logic [4:0] bb;
    logic [5:0] ln;
    longint     exp_full;
    longint     exp_sat;
  } vec_t;

  vec_t vecs [5];
  int   lat;

  initial begin
    vecs[0] = '{ba: 5'd0,  bb: 5'd8,  ln: 6'd4,  exp_full: 70,   exp_sat: 0};
    vecs[1] = '{ba: 5'd5,  bb: 5'd0,  ln: 6'd1,  exp_full: -18,  exp_sat: -1};
    vecs[2] = '{ba: 5'd31, bb: 5'd2,  ln: 6'd3,  exp_full: -30,  exp_sat: -1};
    vecs[3] = '{ba: 5'd10, bb: 5'd10, ln: 6'd2,  exp_full: 173,  exp_sat: 0};
    vecs[4] = '{ba: 5'd0,  bb: 5'd3,  ln: 6'd33, exp_full: 7936, exp_sat: 31};

    reset_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    base_a = '0; base_b = '0; len = '0;
    load_ramp();
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",      longint'(busy), 0);
    check("rst_addr_a",    longint'(address_a), 0);
    check("rst_addr_b",    longint'(address_b), 0);
    check("rst_res_valid", longint'(res_valid), 0);
    check("rst_res_data",  longint'(res_data), 0);
    check("rst_wren",      longint'({wren_a, wren_b}), 0);
    reset_n = 1'b1;

    // Table-driven jobs over the ramp image a[i]=i+1, b[i]=i-3.
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].ba, vecs[i].bb, vecs[i].ln, lat);
      check($sformatf("v%0d_latency", i), lat, longint'(vecs[i].ln) + 3);
      check($sformatf("v%0d_first_addr_a", i), alog[1], longint'(vecs[i].ba));
      check($sformatf("v%0d_first_addr_b", i), alog[1] == 0 ? blog[1] : blog[1],
            longint'(vecs[i].bb));
      check($sformatf("v%0d_last_addr_a", i), alog[vecs[i].ln],
            (longint'(vecs[i].ba) + longint'(vecs[i].ln) - 1) % 32);
      check($sformatf("v%0d_res_data", i), longint'(res_data),
            SAT ? vecs[i].exp_sat : vecs[i].exp_full);
      finish_job($sformatf("v%0d", i));
    end

    // Address sequence of the basic job.
    run_job(5'd0, 5'd8, 6'd4, lat);
    for (int c = 1; c <= 4; c++)
      check($sformatf("seq_addr_a_c%0d", c), alog[c], c - 1);
    finish_job("seq");

    // Address wrap with signed extremes.
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[30] = -16'sd32768; mem_b[30] = -16'sd32768;
    mem_a[31] = -16'sd1;     mem_b[31] = -16'sd1;
    mem_a[0]  = 16'sd2;      mem_b[0]  = 16'sd2;
    run_job(5'd30, 5'd30, 6'd3, lat);
    check("wrap_latency", lat, 6);
    check("wrap_addr_c1", alog[1], 30);
    check("wrap_addr_c2", alog[2], 31);
    check("wrap_addr_c3", alog[3], 0);
    check("wrap_addr_b_c3", blog[3], 0);
    check("wrap_res_data", longint'(res_data), SAT ? 32767 : 1073741829);
    finish_job("wrap");

    // Zero-length job: immediate result, no address movement.
    run_job(5'd7, 5'd9, 6'd0, lat);
    check("len0_latency", lat, 1);
    check("len0_res_data", longint'(res_data), 0);
    check("len0_addr_a", alog[1], 0);
    check("len0_addr_b", blog[1], 0);
    finish_job("len0");

    // Backpressure: result held stable, start ignored while busy.
    load_ramp();
    run_job(5'd0, 5'd8, 6'd4, lat);
    check("bp_latency", lat, 7);
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        if (k == 4) begin
          base_a = 5'd5; base_b = 5'd5; len = 6'd1; start = 1'b1;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        if (res_valid !== 1'b1 || busy !== 1'b1 ||
            longint'(res_data) != (SAT ? 0 : 70))
          bad++;
      end
      check("bp_hold_bad_cycles", bad, 0);
    end
    @(negedge clock);
    res_ready = 1'b1; start = 1'b1; base_a = 5'd5; base_b = 5'd5; len = 6'd1;
    @(posedge clock);
    #1;
    res_ready = 1'b0; start = 1'b0;
    @(negedge clock);
    check("bp_busy_after_hs", longint'(busy), 0);
    repeat (5) @(negedge clock);
    check("bp_handoff_start_ignored", longint'({busy, res_valid}), 0);

    // Reset in cycle 3 of a long job, then a clean short job.
    run_job_abort();
    run_job(5'd0, 5'd8, 6'd2, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_res_data", longint'(res_data), SAT ? 0 : 17);
    finish_job("post_rst");

    // Shift/saturation corner sums (full-width values in the default build).
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[0] = 16'sd32767; mem_b[0] = 16'sd32767;
    mem_a[1] = 16'sd32767; mem_b[1] = 16'sd32767;
    mem_a[2] = -16'sd1024; mem_b[2] = 16'sd1024;
    mem_a[3] = -16'sd1;    mem_b[3] = 16'sd1;
    run_job(5'd0, 5'd0, 6'd2, lat);
    check("sat_pos_res", longint'(res_data), SAT ? 32767 : 2147352578);
    finish_job("sat_pos");
    run_job(5'd2, 5'd2, 6'd1, lat);
    check("sat_neg_res", longint'(res_data), SAT ? -4096 : -1048576);
    finish_job("sat_neg");
    run_job(5'd3, 5'd3, 6'd1, lat);
    check("sat_m1_res", longint'(res_data), -1);
    finish_job("sat_m1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic run_job_abort();
    load_ramp();
    @(negedge clock);
    base_a = 5'd0; base_b = 5'd8; len = 6'd16; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy",      longint'(busy), 0);
    check("abort_addr_a",    longint'(address_a), 0);
    check("abort_addr_b",    longint'(address_b), 0);
    check("abort_res_valid", longint'(res_valid), 0);
    check("abort_res_data",  longint'(res_data), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

endmodule

// File: doc/bram_mac_reader.md
Name: bram_mac_reader

Overview:
- Downstream consumer of the 32x16 true-dual-port feature/weight BRAM in the CNN test datapath.
- On a start pulse it streams len samples via port A and len weights via port B, computes a signed 16x16 multiply-accumulate dot product, and hands the result to the next stage with a valid/ready handshake.
- It never writes the BRAM; wren_a and wren_b are driven low.

Parameters:
- DATA_W, 16, BRAM word width (q_a/q_b, signed two's complement).
- ADDR_W, 5, BRAM address width (32 entries).
- RD_LAT, 2, BRAM read latency: an address presented in cycle t gives q valid in cycle t+RD_LAT. Legal range 1..3.
- ACC_W, 40, accumulator width.
- FRAC_BITS, 8, right shift applied in saturating mode only.

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, honoured only in IDLE
- base_a  in  ADDR_W  first sample address
- base_b  in  ADDR_W  first weight address
- len  in  ADDR_W+1  tap count, 0..63
- busy  out  1  high in any state other than IDLE
- address_a  out  ADDR_W  BRAM port A address, registered
- address_b  out  ADDR_W  BRAM port B address, registered
- wren_a  out  1  constant 0
- wren_b  out  1  constant 0
- q_a  in  DATA_W  BRAM port A read data
- q_b  in  DATA_W  BRAM port B read data
- res_valid  out  1  result available
- res_ready  in  1  downstream accept
- res_data  out  OUT_W  result; OUT_W=ACC_W, or DATA_W when BRAM_MAC_SAT_EN is defined

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; busy=0; address_a=address_b=0; res_valid=0; res_data=0; accumulator=0; all delay-line tags=0.
- FSM states and transitions:
  - IDLE -> ISSUE on start with len>0. Latch base_a, base_b and len; clear the accumulator.
  - IDLE -> HOLD on start with len=0. res_data=0; res_valid goes high in cycle 1.
  - ISSUE: present address_a=base_a+i and address_b=base_b+i, each mod 2^ADDR_W, for i=0..len-1, one tap per cycle starting cycle 1. After the last tap go to DRAIN.
  - DRAIN: wait until the RD_LAT-deep tag pipe is empty and the final product is accumulated, then go to HOLD.
  - HOLD: res_valid=1 and res_data stable. Go to IDLE when res_valid&&res_ready.
- Tag pipe: a 1-bit tag enters alongside each issued address and emerges RD_LAT cycles later. The accumulator adds sext(q_a*q_b) only when the tag is 1, so q values with no tag are ignored.
- Arithmetic:
  - Signed 16x16 multiply gives a 32-bit product, sign-extended to ACC_W.
  - The accumulator wraps two's complement. With defaults, overflow is unreachable (63*2^30 < 2^39).
- Latency: start seen in cycle 0 -> res_valid first high in cycle len+RD_LAT+1.
- Throughput: one tap per cycle, with no bubbles inside ISSUE.
- Address wrap: base+i rolls past 31 back to 0. len>32 re-reads entries.
- start in any state other than IDLE is ignored, including the HOLD->IDLE handoff cycle. A new job needs start in a cycle where busy=0.
- base_a, base_b and len changing after acceptance have no effect.
- res_ready low holds HOLD indefinitely; res_data must not change while held.
- reset_n low mid-job aborts immediately to the reset values. In-flight BRAM data is discarded.

Optional Feature:
- Macro: BRAM_MAC_SAT_EN.
- Defined: res_data is DATA_W wide. It equals acc arithmetically shifted right by FRAC_BITS, saturated to [-32768, 32767]. Rounding is truncation toward negative infinity.
- Not defined: res_data is the full ACC_W accumulator, with no shift or saturation logic.

Decomposition:
- Package bram_mac_pkg:
  - state enum {IDLE, ISSUE, DRAIN, HOLD};
  - DATA_W/ADDR_W/ACC_W defaults;
  - SAT_MAX/SAT_MIN constants;
  - saturate function, used only under the macro.
- Sub-module rd_lat_pipe: parameterised RD_LAT-deep tag shift register with async active-low reset, reused wherever BRAM latency alignment is needed.

Test Plan:
- BRAM model with RD_LAT=2: data[0..3]={1,2,3,4}, weights[8..11]={5,6,7,8}; start with base_a=0, base_b=8, len=4 -> res_valid in cycle 7, res_data=70; address_a sequence 0,1,2,3 in cycles 1-4.
- Wrap and sign: base_a=30, base_b=30, len=3; entries 30,31,0 hold {-32768,-1,2} on both ports -> addresses 30,31,0; res_data=2^30+1+4=1073741829.
- len=0 -> res_valid in cycle 1 with res_data=0; no address change occurs.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid; pulse start during HOLD -> res_data stable, start ignored, busy=1. After the handshake, busy=0 next cycle.
- reset_n low in cycle 3 of a len=16 job -> all outputs at reset values; a subsequent len=2 job produces the correct sum with no residue.
- BRAM_MAC_SAT_EN with FRAC_BITS=8: sum 32767*32767*2 -> 32767; sum -(2^20) -> -4096; sum -1 -> -1.
